touch_voice_allocator: RTL
==========================

# touch_voice_allocator

Parametrised polyphonic voice allocator between the touch-sensor front end and the oscillator/envelope bank. Tracks press/release edges on NUM_KEYS touch lines and assigns each pressed key to one of NUM_VOICES voice slots, producing per-voice gate, one-cycle trigger and key index. It replaces the single-note, one-hot decode with deterministic multi-key handling, pending-press buffering and optional oldest-voice stealing.

## Interface
- NUM_KEYS, 24, number of touch lines (≥2)
- NUM_VOICES, 4, number of voice slots (≥2, power of two not required)
- KEY_W, $clog2(NUM_KEYS), key index width (derived, do not override)
- clk_in  input  1  system clock; single clock domain
- rst_in  input  1  reset; asynchronous, active-high
- touch_status_in  input  NUM_KEYS  level per key, 1 = touched; synchronous to clk_in
- voice_gate_out  output  NUM_VOICES  1 while voice holds a key
- voice_trigger_out  output  NUM_VOICES  one-cycle pulse when voice receives a (new) key
- voice_key_out  output  NUM_VOICES×KEY_W  key index held by each voice
- last_key_out  output  KEY_W  key most recently allocated to any voice
- pending_out  output  1  at least one press awaiting allocation

## Operation
- Registers: touch_q (previous touch), pending mask (NUM_KEYS), per-voice gate/key, per-voice age rank (0 = newest, NUM_VOICES-1 = oldest), trigger regs, last_key.
- press = touch_status_in & ~touch_q; release = ~touch_status_in & touch_q.
- Pending mask: set by press, cleared by release of that key or by allocation of that key.
- Each cycle at most one allocation: candidate = lowest-index key in (pending | press) that is still touched.
- Target voice: lowest-index voice with gate=0. If none free: see Configuration.
- On allocation: voice gate←1, key←candidate, trigger←1 for one cycle, age←0, every voice with age lower than target's old age increments; last_key←candidate.
- Release: every voice whose key matches a released key drops gate the same edge; age ranks unchanged; voice_key_out holds last value.
- A key is held by at most one voice; a key pressed, released and re-pressed gets a fresh allocation.
- Release and allocation in the same cycle: release processed first, freed voice is eligible as target.
- Press and release of same key never coincide (edge-based); press-then-release before service → key removed from pending, never allocated.

## Timing
- Reset (async): all gates 0, triggers 0, keys 0, last_key 0, pending 0, touch_q 0, ages = voice index.
- Single press, free voice: gate and trigger high 1 cycle after touch rises; trigger low next cycle.
- k simultaneous presses: allocated lowest index first, one per cycle, cycles 1..k.
- Release: gate low 1 cycle after touch falls.
- pending_out registered; high while pending mask nonzero.
- Reset mid-operation: all outputs to reset values immediately; held touches after reset are seen as new presses.

## Configuration
- VOICE_ALLOC_STEAL_EN defined: when all voices busy, the oldest-rank voice is stolen; gate stays 1, key changes, trigger pulses, age←0.
- Not defined: when all voices busy, press stays pending until a voice frees (or key released); no stealing, held voices never change key.

## Structure
- Package touch_voice_pkg: age-rank type helper, reset constant for age vector, function returning lowest set index of a vector.
- Sub-module lowest_set_idx (parametrised width, outputs index and found flag), instantiated twice: key candidate and free voice.
- All state in one always_ff with async reset; allocation decision in one always_comb.

## Test plan
- Reset: assert rst_in mid-cycle with gates active -> all outputs zero immediately, ages 0..3.
- Key 5 touched alone -> voice 0 gate=1, key=5, trigger one cycle after; release -> voice 0 gate=0 one cycle later.
- Keys 2,7,9 rise in same cycle -> voices 0,1,2 get keys 2,7,9 on cycles 1,2,3, one trigger each; pending_out low after cycle 3.
- Keys 0–3 held, key 10 pressed, STEAL_EN defined -> voice holding key 0 (oldest) gets key 10, gate stays 1, trigger pulses.
- Same as above, STEAL_EN undefined -> no change, pending_out=1; release key 1 -> its voice gets key 10 next cycle.
- Key 4 pressed and released before service (all voices busy, no steal) -> never allocated, pending clears.

Source files
------------

// File: rtl/touch_voice_pkg.sv
// Shared helpers for the touch voice allocator: index widths, age-rank reset
// values and a lowest-set-bit search.
package touch_voice_pkg;

  localparam int LSI_MAX_W = 64;

  // Width of an index or age rank over n items, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // After reset each voice's age rank equals its own index.
  function automatic int age_rank_reset(input int voice);
    return voice;
  endfunction

  // Returns -1 when no bit is set.
  function automatic int lowest_set(input logic [LSI_MAX_W-1:0] vec);
    int pos;
    pos = -1;
    for (int i = LSI_MAX_W - 1; i >= 0; i--) begin
      if (vec[i]) pos = i;
    end
    return pos;
  endfunction

endpackage

// File: rtl/lowest_set_idx.sv
// Priority encoder: index of the lowest set bit of vec, plus a found flag.
// Supports widths up to touch_voice_pkg::LSI_MAX_W.
module lowest_set_idx
  import touch_voice_pkg::*;
#(
  parameter int W = 8,
  localparam int IW = idx_w(W)
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  int pos;

  always_comb begin
    pos   = lowest_set(LSI_MAX_W'(vec));
    found = (pos >= 0);
    idx   = found ? IW'(pos) : '0;
  end

endmodule

// File: rtl/touch_voice_allocator.sv
// Polyphonic voice allocator: press/release edge tracking, pending buffering,
// one allocation per cycle. Define VOICE_ALLOC_STEAL_EN to steal the oldest voice.
module touch_voice_allocator
  import touch_voice_pkg::*;
#(
  parameter int NUM_KEYS   = 24,
  parameter int NUM_VOICES = 4,
  localparam int KEY_W     = $clog2(NUM_KEYS)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [NUM_KEYS-1:0]         touch_status_in,
  output logic [NUM_VOICES-1:0]       voice_gate_out,
  output logic [NUM_VOICES-1:0]       voice_trigger_out,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key_out,
  output logic [KEY_W-1:0]            last_key_out,
  output logic                        pending_out
);

  localparam int VW = idx_w(NUM_VOICES);

  logic [NUM_KEYS-1:0]   touch_q, pending_q, pending_d;
  logic [NUM_KEYS-1:0]   press, rel, cand_vec;
  logic [NUM_VOICES-1:0] gate_q, gate_d, trig_q, trig_d, gate_rel, free_vec;
  logic [KEY_W-1:0]      key_q [NUM_VOICES];
  logic [KEY_W-1:0]      key_d [NUM_VOICES];
  logic [VW-1:0]         age_q [NUM_VOICES];
  logic [VW-1:0]         age_d [NUM_VOICES];
  logic [KEY_W-1:0]      last_q, last_d, cand_idx;
  logic [VW-1:0]         free_idx, target;
  logic                  cand_found, free_found, do_alloc;

  assign press    = touch_status_in & ~touch_q;
  assign rel      = ~touch_status_in & touch_q;
  // Pending keys released this cycle drop out because they are no longer touched.
  assign cand_vec = (pending_q | press) & touch_status_in;

  // Releases are applied before allocation so a freed voice is usable this cycle.
  always_comb begin
    gate_rel = gate_q;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (rel[key_q[v]]) gate_rel[v] = 1'b0;
    end
  end

  assign free_vec = ~gate_rel;

  lowest_set_idx #(.W(NUM_KEYS)) u_key_pick (
    .vec   (cand_vec),
    .idx   (cand_idx),
    .found (cand_found)
  );

  lowest_set_idx #(.W(NUM_VOICES)) u_voice_pick (
    .vec   (free_vec),
    .idx   (free_idx),
    .found (free_found)
  );

`ifdef VOICE_ALLOC_STEAL_EN
  logic [VW-1:0] oldest_idx;

  always_comb begin
    oldest_idx = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (age_q[v] == VW'(NUM_VOICES - 1)) oldest_idx = VW'(v);
    end
  end

  assign do_alloc = cand_found;
  assign target   = free_found ? free_idx : oldest_idx;
`else
  assign do_alloc = cand_found & free_found;
  assign target   = free_idx;
`endif

  always_comb begin
    pending_d = cand_vec;
    gate_d    = gate_rel;
    trig_d    = '0;
    last_d    = last_q;
    for (int v = 0; v < NUM_VOICES; v++) begin
      key_d[v] = key_q[v];
      age_d[v] = age_q[v];
    end
    if (do_alloc) begin
      pending_d[cand_idx] = 1'b0;
      last_d              = cand_idx;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (VW'(v) == target) begin
          gate_d[v] = 1'b1;
          trig_d[v] = 1'b1;
          key_d[v]  = cand_idx;
          age_d[v]  = '0;
        end else if (age_q[v] < age_q[target]) begin
          age_d[v] = age_q[v] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      touch_q   <= '0;
      pending_q <= '0;
      gate_q    <= '0;
      trig_q    <= '0;
      last_q    <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_q[v] <= '0;
        age_q[v] <= VW'(age_rank_reset(v));
      end
    end else begin
      touch_q   <= touch_status_in;
      pending_q <= pending_d;
      gate_q    <= gate_d;
      trig_q    <= trig_d;
      last_q    <= last_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_q[v] <= key_d[v];
        age_q[v] <= age_d[v];
      end
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_key_out
    assign voice_key_out[v*KEY_W +: KEY_W] = key_q[v];
  end

  assign voice_gate_out    = gate_q;
  assign voice_trigger_out = trig_q;
  assign last_key_out      = last_q;
  assign pending_out       = |pending_q;

endmodule
